vector_operand_fetch: RTL and testbench

VECTOR_OPERAND_FETCH -- requirements
Module: vector_operand_fetch

---
 rtl/vector_operand_fetch.sv | 157 +++++++++++++++
 tb/tb_vector_operand_fetch.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_operand_fetch.sv
// vector_operand_fetch
//   Fetches one pair of vector operands from a register file whose read
//   ports are narrower than a vector. Each vector is read as three
//   64-bit chunks over three strobe cycles. Each returning chunk is placed
//   into op1/op2. A one-cycle flag marks the point where both operands and
//   the latched operation code are complete.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   fetch request, sampled only while idle
//   rs1, rs2   in   source vector register indices
//   funct_in   in   operation code passed through to the adder
//   rf_rd_en   out  register-file read strobe
//   rf_addr1/2 out  read addresses {rs, chunk}, zero when not strobing
//   rf_rdata1/2 in  read data, valid one cycle after the strobe
//   op1, op2   out  assembled operands (lane 0 = bits 7:0)
//   flag       out  one-cycle strobe: op1/op2/funct valid
//   funct      out  latched operation code
//   busy       out  high whenever a fetch is in progress
module vector_operand_fetch #(
    parameter int unsigned LANES   = 24,
    parameter int unsigned LANE_W  = 8,
    parameter int unsigned CHUNK_W = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [3:0]                rs1,
    input  logic [3:0]                rs2,
    input  logic [2:0]                funct_in,
    output logic                      rf_rd_en,
    output logic [5:0]                rf_addr1,
    output logic [5:0]                rf_addr2,
    input  logic [CHUNK_W-1:0]        rf_rdata1,
    input  logic [CHUNK_W-1:0]        rf_rdata2,
    output logic [LANES*LANE_W-1:0]   op1,
    output logic [LANES*LANE_W-1:0]   op2,
    output logic                      flag,
    output logic [2:0]                funct,
    output logic                      busy
);

    localparam int unsigned VEC_W      = LANES * LANE_W;
    localparam int unsigned NCHUNK     = VEC_W / CHUNK_W;
    localparam logic [1:0]  LAST_CHUNK = 2'(NCHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [3:0]         rs1_q, rs1_d;
    logic [3:0]         rs2_q, rs2_d;
    logic [2:0]         funct_q, funct_d;
    // Tracks which chunk the read data on the bus belongs to. The data
    // arrives one cycle after its strobe.
    logic               cap_v_q, cap_v_d;
    logic [1:0]         cap_idx_q, cap_idx_d;
    logic [VEC_W-1:0]   op1_q, op1_d;
    logic [VEC_W-1:0]   op2_q, op2_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            funct_q   <= '0;
            cap_v_q   <= 1'b0;
            cap_idx_q <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            funct_q   <= funct_d;
            cap_v_q   <= cap_v_d;
            cap_idx_q <= cap_idx_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        funct_d   = funct_q;
        rf_rd_en  = 1'b0;
        rf_addr1  = '0;
        rf_addr2  = '0;
        flag      = 1'b0;
        busy      = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rs1_d   = rs1;
                    rs2_d   = rs2;
                    funct_d = funct_in;
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                rf_rd_en = 1'b1;
                rf_addr1 = {rs1_q, cnt_q};
                rf_addr2 = {rs2_q, cnt_q};
                cnt_d    = cnt_q + 2'd1;
                if (cnt_q == LAST_CHUNK) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                flag    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Chunk capture. Older chunks of a previous fetch remain until this
    // fetch overwrites them one by one.
    always_comb begin
        cap_v_d   = rf_rd_en;
        cap_idx_d = cnt_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        if (cap_v_q) begin
            for (int unsigned k = 0; k < NCHUNK; k++) begin
                if (cap_idx_q == 2'(k)) begin
                    op1_d[k*CHUNK_W +: CHUNK_W] = rf_rdata1;
                    op2_d[k*CHUNK_W +: CHUNK_W] = rf_rdata2;
                end
            end
        end
    end

    assign op1   = op1_q;
    assign op2   = op2_q;
    assign funct = funct_q;

endmodule

// File: tb/tb_vector_operand_fetch.sv
module tb_vector_operand_fetch;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   rs1, rs2;
    logic [2:0]   funct_in;
    logic         rf_rd_en;
    logic [5:0]   rf_addr1, rf_addr2;
    logic [63:0]  rf_rdata1, rf_rdata2;
    logic [191:0] op1, op2;
    logic         flag;
    logic [2:0]   funct;
    logic         busy;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [63:0] mem [64];

    vector_operand_fetch #(
        .LANES  (24),
        .LANE_W (8),
        .CHUNK_W(64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rs1      (rs1),
        .rs2      (rs2),
        .funct_in (funct_in),
        .rf_rd_en (rf_rd_en),
        .rf_addr1 (rf_addr1),
        .rf_addr2 (rf_addr2),
        .rf_rdata1(rf_rdata1),
        .rf_rdata2(rf_rdata2),
        .op1      (op1),
        .op2      (op2),
        .flag     (flag),
        .funct    (funct),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Register file model: data returned one cycle after the strobe.
    always @(posedge clk) begin
        if (rf_rd_en) begin
            rf_rdata1 <= mem[rf_addr1];
            rf_rdata2 <= mem[rf_addr2];
        end else begin
            rf_rdata1 <= 64'hDEAD_BEEF_DEAD_BEEF;
            rf_rdata2 <= 64'hDEAD_BEEF_DEAD_BEEF;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] b;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (r == 2) begin
                    b = 8'h11 * 8'(c + 1);
                end else begin
                    b = 8'(r);
                end
                mem[r*4 + c] = {8{b}};
            end
        end

        rst = 1'b1; start = 1'b0; rs1 = '0; rs2 = '0; funct_in = '0;
        cyc(); cyc();
        check("rst_busy", 192'(busy), 192'(0));
        check("rst_flag", 192'(flag), 192'(0));
        check("rst_rden", 192'(rf_rd_en), 192'(0));
        check("rst_addr1", 192'(rf_addr1), 192'(0));
        check("rst_addr2", 192'(rf_addr2), 192'(0));
        check("rst_op1", op1, 192'(0));
        check("rst_op2", op2, 192'(0));
        check("rst_funct", 192'(funct), 192'(0));
        rst = 1'b0;
        cyc();

        // Basic fetch: rs1=3, rs2=5, funct=1.
        start = 1'b1; rs1 = 4'd3; rs2 = 4'd5; funct_in = 3'd1;
        cyc();  // T+1
        start = 1'b0; rs1 = 4'd0; rs2 = 4'd0; funct_in = 3'd0;
        check("t1_rden1", 192'(rf_rd_en), 192'(1));
        check("t1_a1_c0", 192'(rf_addr1), 192'(6'h0C));
        check("t1_a2_c0", 192'(rf_addr2), 192'(6'h14));
        check("t1_busy", 192'(busy), 192'(1));
        cyc();  // T+2
        check("t1_a1_c1", 192'(rf_addr1), 192'(6'h0D));
        check("t1_a2_c1", 192'(rf_addr2), 192'(6'h15));
        cyc();  // T+3
        check("t1_a1_c2", 192'(rf_addr1), 192'(6'h0E));
        check("t1_a2_c2", 192'(rf_addr2), 192'(6'h16));
        check("t1_flag3", 192'(flag), 192'(0));
        cyc();  // T+4
        check("t1_drain_rden", 192'(rf_rd_en), 192'(0));
        check("t1_drain_addr1", 192'(rf_addr1), 192'(0));
        check("t1_drain_flag", 192'(flag), 192'(0));
        check("t1_drain_busy", 192'(busy), 192'(1));
        cyc();  // T+5
        check("t1_flag", 192'(flag), 192'(1));
        check("t1_flag_rden", 192'(rf_rd_en), 192'(0));
        check("t1_op1", op1, {24{8'h03}});
        check("t1_op2", op2, {24{8'h05}});
        check("t1_funct", 192'(funct), 192'(1));
        cyc();  // T+6
        check("t1_idle_flag", 192'(flag), 192'(0));
        check("t1_idle_busy", 192'(busy), 192'(0));
        check("t1_hold_op1", op1, {24{8'h03}});
        cyc();

        // Chunk ordering and progressive overwrite: rs1=2, rs2=4.
        start = 1'b1; rs1 = 4'd2; rs2 = 4'd4; funct_in = 3'd6;
        cyc();  // T+1
        start = 1'b0;
        cyc();  // T+2
        cyc();  // T+3
        check("t2_partial_lo", op1[63:0], 192'(64'h1111_1111_1111_1111));
        check("t2_partial_hi", op1[191:128], 192'(64'h0303_0303_0303_0303));
        cyc(); cyc();  // T+5
        check("t2_flag", 192'(flag), 192'(1));
        check("t2_op1_lo", op1[63:0], 192'(64'h1111_1111_1111_1111));
        check("t2_op1_hi", op1[191:128], 192'(64'h3333_3333_3333_3333));
        check("t2_op1", op1, {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222,
                              64'h1111_1111_1111_1111});
        check("t2_op2", op2, {24{8'h04}});
        check("t2_funct", 192'(funct), 192'(6));
        cyc();
        cyc();

        // start held high: flags at T+5, T+11, T+17.
        start = 1'b1; rs1 = 4'd1; rs2 = 4'd6; funct_in = 3'd2;
        for (int k = 1; k <= 17; k++) begin
            cyc();
            check($sformatf("t3_flag_%0d", k), 192'(flag), 192'((k % 6) == 5));
            check($sformatf("t3_busy_%0d", k), 192'(busy), 192'((k % 6) != 0));
        end
        start = 1'b0;
        cyc();  // T+18 idle
        check("t3_op1", op1, {24{8'h01}});
        cyc();
        check("t3_no_more", 192'(busy), 192'(0));

        // Reset in T+3 mid-fetch.
        start = 1'b1; rs1 = 4'd3; rs2 = 4'd5; funct_in = 3'd7;
        cyc();  // T+1
        start = 1'b0;
        cyc();  // T+2
        cyc();  // T+3
        rst = 1'b1;
        cyc();  // T+4
        rst = 1'b0;
        check("t4_busy", 192'(busy), 192'(0));
        check("t4_rden", 192'(rf_rd_en), 192'(0));
        check("t4_op1", op1, 192'(0));
        check("t4_op2", op2, 192'(0));
        check("t4_funct", 192'(funct), 192'(0));
        for (int k = 5; k <= 7; k++) begin
            cyc();
            check($sformatf("t4_noflag_%0d", k), 192'(flag), 192'(0));
            check($sformatf("t4_discard_%0d", k), op1, 192'(0));
        end
        // start together with rst is ignored.
        rst = 1'b1; start = 1'b1; rs1 = 4'd9;
        cyc();
        rst = 1'b0; start = 1'b0;
        check("t4_rststart_busy", 192'(busy), 192'(0));
        cyc();
        check("t4_rststart_busy2", 192'(busy), 192'(0));
        // Normal fetch after reset.
        start = 1'b1; rs1 = 4'd5; rs2 = 4'd3; funct_in = 3'd4;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            start = 1'b0;
            check($sformatf("t4b_flag_%0d", k), 192'(flag), 192'(k == 5));
            if (k == 5) begin
                check("t4b_op1", op1, {24{8'h05}});
                check("t4b_op2", op2, {24{8'h03}});
                check("t4b_funct", 192'(funct), 192'(4));
            end
        end

        // start pulsed in T+2 while busy is ignored.
        start = 1'b1; rs1 = 4'd3; rs2 = 4'd5; funct_in = 3'd2;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            start = (k == 2);
            if (k == 2) begin
                rs1 = 4'd7; rs2 = 4'd7; funct_in = 3'd5;
            end
            check($sformatf("t5_flag_%0d", k), 192'(flag), 192'(k == 5));
            if (k == 3) check("t5_addr1_c2", 192'(rf_addr1), 192'(6'h0E));
            if (k == 5) begin
                check("t5_op1", op1, {24{8'h03}});
                check("t5_op2", op2, {24{8'h05}});
                check("t5_funct", 192'(funct), 192'(2));
            end
            if (k == 7) check("t5_idle", 192'(busy), 192'(0));
        end
        start = 1'b0;

        // rs1 == rs2 == 7.
        start = 1'b1; rs1 = 4'd7; rs2 = 4'd7; funct_in = 3'd3;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            start = 1'b0;
            check($sformatf("t6_excl_%0d", k), 192'(rf_rd_en & flag), 192'(0));
            if (k <= 3) begin
                check($sformatf("t6_a1_%0d", k), 192'(rf_addr1), 192'({4'd7, 2'(k - 1)}));
                check($sformatf("t6_a2_%0d", k), 192'(rf_addr2), 192'({4'd7, 2'(k - 1)}));
            end
            if (k == 5) begin
                check("t6_flag", 192'(flag), 192'(1));
                check("t6_op1", op1, {24{8'h07}});
                check("t6_op2", op2, {24{8'h07}});
            end
        end
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
